// File: rtl/uart_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// uart_ctrl_pkg
// Shared types for the UART transmit scheduler: the scheduler state encoding,
// the default requester count and the byte-length type (byte count minus 1).
// ---------------------------------------------------------------------------
package uart_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_START   = 2'd1,
      S_WAIT_HI = 2'd2,
      S_WAIT_LO = 2'd3
   } sched_state_t;

   localparam int N_REQ_DEFAULT = 2;

   typedef logic [1:0] blen_t;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: returns the first asserted request at
// or after ptr, wrapping around to index 0.
// Ports:
//   req  in  N      request vector
//   ptr  in  IDX_W  highest-priority index for this pick
//   gnt  out N      one-hot grant (all zero when no request)
//   idx  out IDX_W  index of the granted request (0 when none)
//   any  out 1      at least one request is asserted
// ---------------------------------------------------------------------------
module rr_arbiter
   import uart_ctrl_pkg::*;
#(
   parameter  int N     = N_REQ_DEFAULT,
   localparam int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   always_comb begin
      int   p;
      logic found;
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      p     = 0;
      // Walk N positions starting at ptr; the first hit wins.
      for (int o = 0; o < N; o++) begin
         p = int'(ptr) + o;
         if (p >= N) begin
            p = p - N;
         end
         if (!found && req[p]) begin
            found  = 1'b1;
            gnt[p] = 1'b1;
            idx    = IDX_W'(p);
         end
      end
      any = found;
   end

endmodule

// File: rtl/uart_tx_sched.sv
// ---------------------------------------------------------------------------
// uart_tx_sched
// Shares one uart_tx serializer among N_REQ requesters. One 1..4 byte word is
// accepted at a time (round-robin), then sent LSB byte first using the
// tx_start / tx_busy handshake of uart_tx.
// Ports:
//   clk        in   1          system clock
//   rstn       in   1          asynchronous active-low reset
//   req_valid  in   N_REQ      requester i has a word pending
//   req_data   in   N_REQ*32   word of requester i at [32*i +: 32]
//   req_len    in   N_REQ*2    byte count minus 1 of requester i at [2*i +: 2]
//   req_ready  out  N_REQ      one-hot, one-cycle accept pulse
//   sdata      out  8          byte to uart_tx
//   tx_start   out  1          one-cycle start pulse to uart_tx
//   tx_busy    in   1          uart_tx busy (rises the cycle after tx_start)
//   sched_busy out  1          a word is in flight
//   grant_id   out  IDX_W      requester being served
// ---------------------------------------------------------------------------
module uart_tx_sched
   import uart_ctrl_pkg::*;
#(
   parameter  int N_REQ = N_REQ_DEFAULT,
   localparam int IDX_W = $clog2(N_REQ)
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [N_REQ-1:0]  req_valid,
   input  logic [N_REQ*32-1:0] req_data,
   input  logic [N_REQ*2-1:0]  req_len,
   output logic [N_REQ-1:0]  req_ready,
   output logic [7:0]        sdata,
   output logic              tx_start,
   input  logic              tx_busy,
   output logic              sched_busy,
   output logic [IDX_W-1:0]  grant_id
);

   sched_state_t     state_reg,      state_next;
   logic [IDX_W-1:0] rr_ptr_reg,     rr_ptr_next;
   logic [IDX_W-1:0] grant_reg,      grant_next;
   blen_t            byte_cnt_reg,   byte_cnt_next;
   blen_t            len_reg,        len_next;
   logic [31:0]      data_reg,       data_next;
   logic [N_REQ-1:0] ready_reg,      ready_next;
   logic [7:0]       sdata_reg,      sdata_next;
   logic             tx_start_reg,   tx_start_next;
   logic             sched_busy_reg, sched_busy_next;

   logic [N_REQ-1:0] arb_gnt;
   logic [IDX_W-1:0] arb_idx;
   logic             arb_any;
   logic [31:0]      sel_data;
   blen_t            sel_len;

   rr_arbiter #(.N(N_REQ)) u_arb (
      .req (req_valid),
      .ptr (rr_ptr_reg),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .any (arb_any)
   );

   // Word/length of the granted requester (one-hot select).
   always_comb begin
      sel_data = '0;
      sel_len  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (arb_gnt[i]) begin
            sel_data = req_data[32*i +: 32];
            sel_len  = req_len[2*i +: 2];
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg      <= S_IDLE;
         rr_ptr_reg     <= '0;
         grant_reg      <= '0;
         byte_cnt_reg   <= '0;
         len_reg        <= '0;
         data_reg       <= '0;
         ready_reg      <= '0;
         sdata_reg      <= '0;
         tx_start_reg   <= 1'b0;
         sched_busy_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         rr_ptr_reg     <= rr_ptr_next;
         grant_reg      <= grant_next;
         byte_cnt_reg   <= byte_cnt_next;
         len_reg        <= len_next;
         data_reg       <= data_next;
         ready_reg      <= ready_next;
         sdata_reg      <= sdata_next;
         tx_start_reg   <= tx_start_next;
         sched_busy_reg <= sched_busy_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      rr_ptr_next     = rr_ptr_reg;
      grant_next      = grant_reg;
      byte_cnt_next   = byte_cnt_reg;
      len_next        = len_reg;
      data_next       = data_reg;
      ready_next      = '0;
      sdata_next      = sdata_reg;
      tx_start_next   = 1'b0;
      sched_busy_next = sched_busy_reg;

      case (state_reg)
         S_IDLE: begin
            // A still-busy serializer (e.g. just after reset) holds off arbitration.
            if (arb_any && !tx_busy) begin
               ready_next      = arb_gnt;
               data_next       = sel_data;
               len_next        = sel_len;
               grant_next      = arb_idx;
               byte_cnt_next   = '0;
               sched_busy_next = 1'b1;
               rr_ptr_next     = (arb_idx == IDX_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
               state_next      = S_START;
            end
         end
         S_START: begin
            sdata_next    = data_reg[{byte_cnt_reg, 3'b000} +: 8];
            tx_start_next = 1'b1;
            state_next    = S_WAIT_HI;
         end
         S_WAIT_HI: begin
            // tx_busy lags tx_start by a cycle, so a low here is not completion.
            if (tx_busy) begin
               state_next = S_WAIT_LO;
            end
         end
         S_WAIT_LO: begin
            if (!tx_busy) begin
               if (byte_cnt_reg == len_reg) begin
                  sched_busy_next = 1'b0;
                  state_next      = S_IDLE;
               end else begin
                  byte_cnt_next = byte_cnt_reg + 1'b1;
                  state_next    = S_START;
               end
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   assign req_ready  = ready_reg;
   assign sdata      = sdata_reg;
   assign tx_start   = tx_start_reg;
   assign sched_busy = sched_busy_reg;
   assign grant_id   = grant_reg;

endmodule

// File: tb/tb_uart_tx_sched.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_sched
// Drives uart_tx_sched with two requesters, a small uart_tx model
// (CLK_PER_HALF_BIT=4) and a uart_rx model on txd. Expected grants and bytes
// are queued when stimulus is issued and compared as the DUT produces them.
// ---------------------------------------------------------------------------
module tb_uart_tx_sched;

   localparam int CPH = 4;
   localparam int BIT = 2 * CPH;

   logic        clk;
   logic        rstn;
   logic [1:0]  req_valid;
   logic [63:0] req_data;
   logic [3:0]  req_len;
   logic [1:0]  req_ready;
   logic [7:0]  sdata;
   logic        tx_start;
   logic        tx_busy;
   logic        sched_busy;
   logic [0:0]  grant_id;
   logic        txd;

   uart_tx_sched #(.N_REQ(2)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_len    (req_len),
      .req_ready  (req_ready),
      .sdata      (sdata),
      .tx_start   (tx_start),
      .tx_busy    (tx_busy),
      .sched_busy (sched_busy),
      .grant_id   (grant_id)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- uart_tx model: 1 start, 8 data LSB first, 1 stop
   logic [8:0] tx_sh;
   int         tx_bitn;
   int         tx_tcnt;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tx_busy <= 1'b0;
         txd     <= 1'b1;
         tx_sh   <= '0;
         tx_bitn <= 0;
         tx_tcnt <= 0;
      end else if (!tx_busy) begin
         if (tx_start) begin
            tx_busy <= 1'b1;
            txd     <= 1'b0;
            tx_sh   <= {1'b1, sdata};
            tx_bitn <= 0;
            tx_tcnt <= 0;
         end
      end else if (tx_tcnt == BIT - 1) begin
         tx_tcnt <= 0;
         if (tx_bitn == 9) begin
            tx_busy <= 1'b0;
         end else begin
            txd     <= tx_sh[0];
            tx_sh   <= {1'b0, tx_sh[8:1]};
            tx_bitn <= tx_bitn + 1;
         end
      end else begin
         tx_tcnt <= tx_tcnt + 1;
      end
   end

   // ---------------- uart_rx model: samples mid-bit, pushes each byte
   logic       rx_active;
   int         rx_m;
   logic [7:0] rx_sh;
   logic [7:0] rx_q[$];

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rx_active <= 1'b0;
         rx_m      <= 0;
         rx_sh     <= '0;
      end else if (!rx_active) begin
         if (txd == 1'b0) begin
            rx_active <= 1'b1;
            rx_m      <= 1;
         end
      end else begin
         if ((rx_m % BIT) == (BIT / 2 - 1) && (rx_m / BIT) >= 1 && (rx_m / BIT) <= 8) begin
            rx_sh[rx_m / BIT - 1] <= txd;
         end
         if (rx_m == 9 * BIT + BIT / 2 - 1) begin
            rx_q.push_back(rx_sh);
            rx_active <= 1'b0;
         end
         rx_m <= rx_m + 1;
      end
   end

   // ---------------- scoreboard state
   logic [33:0] pend0_q[$];
   logic [33:0] pend1_q[$];
   logic        exp_grant_q[$];
   logic [7:0]  exp_byte_q[$];

   int   checks;
   int   passes;
   int   cyc;
   int   ts_cnt;
   int   lat_t0;
   logic lat_arm;
   logic lat_ts_arm;
   logic prev_ts;
   logic prev_rdy;
   logic prev_sb;
   logic cur_grant;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) begin
         passes++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic expect_word(input logic g, input logic [31:0] data, input int len);
      exp_grant_q.push_back(g);
      for (int b = 0; b <= len; b++) begin
         exp_byte_q.push_back(data[8*b +: 8]);
      end
   endtask

   // One cycle: observe at the falling edge, then update requester inputs.
   task automatic tick();
      logic        g;
      logic [7:0]  b;
      logic [33:0] w;
      @(negedge clk);
      cyc++;
      if (tx_start) begin
         check("start_gap", 32'(tx_busy | prev_ts), 32'd0);
         ts_cnt++;
         if (lat_ts_arm) begin
            check("lat_start", 32'(cyc - lat_t0), 32'd2);
            lat_ts_arm = 1'b0;
         end
      end
      if (req_ready != 2'b00) begin
         check("ready_pulse", 32'(prev_rdy), 32'd0);
         check("grant_expected", 32'(exp_grant_q.size() > 0), 32'd1);
         if (exp_grant_q.size() > 0) begin
            g = exp_grant_q.pop_front();
            check("grant", 32'(req_ready), 32'(1 << g));
            cur_grant = g;
            $display("grant: requester %0d accepted at cycle %0d", g, cyc);
         end
         if (lat_arm) begin
            check("lat_ready", 32'(cyc - lat_t0), 32'd1);
            lat_arm    = 1'b0;
            lat_ts_arm = 1'b1;
         end
      end
      if (sched_busy && req_ready == 2'b00) begin
         check("grant_id", 32'(grant_id), 32'(cur_grant));
      end
      if (prev_sb && !sched_busy && rstn) begin
         check("busy_fall", 32'(tx_busy), 32'd0);
      end
      if (tx_busy) begin
         check("busy_cover", 32'(sched_busy), 32'd1);
      end
      while (rx_q.size() > 0) begin
         b = rx_q.pop_front();
         check("rx_expected", 32'(exp_byte_q.size() > 0), 32'd1);
         if (exp_byte_q.size() > 0) begin
            check("rx_byte", 32'(b), 32'(exp_byte_q.pop_front()));
            $display("rx: byte %02h at cycle %0d", b, cyc);
         end
      end
      prev_ts  = tx_start;
      prev_rdy = |req_ready;
      prev_sb  = sched_busy;
      for (int i = 0; i < 2; i++) begin
         if (req_valid[i] && req_ready[i]) begin
            req_valid[i] = 1'b0;
         end
      end
      if (!req_valid[0] && pend0_q.size() > 0) begin
         w = pend0_q.pop_front();
         req_data[31:0] = w[31:0];
         req_len[1:0]   = w[33:32];
         req_valid[0]   = 1'b1;
         lat_t0         = cyc;
      end
      if (!req_valid[1] && pend1_q.size() > 0) begin
         w = pend1_q.pop_front();
         req_data[63:32] = w[31:0];
         req_len[3:2]    = w[33:32];
         req_valid[1]    = 1'b1;
         lat_t0          = cyc;
      end
   endtask

   task automatic wait_done(input int budget);
      logic done;
      done = 1'b0;
      for (int k = 0; k < budget; k++) begin
         tick();
         done = !sched_busy && !tx_busy && req_valid == 2'b00 &&
                pend0_q.size() == 0 && pend1_q.size() == 0 &&
                exp_grant_q.size() == 0 && exp_byte_q.size() == 0;
         if (done) break;
      end
      check("drain_done", 32'(done), 32'd1);
   endtask

   task automatic check_reset_outputs();
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_sdata", 32'(sdata), 32'd0);
      check("rst_tx_start", 32'(tx_start), 32'd0);
      check("rst_sched_busy", 32'(sched_busy), 32'd0);
      check("rst_grant_id", 32'(grant_id), 32'd0);
      check("rst_txd", 32'(txd), 32'd1);
   endtask

   initial begin
      checks     = 0;
      passes     = 0;
      cyc        = 0;
      ts_cnt     = 0;
      lat_t0     = 0;
      lat_arm    = 1'b0;
      lat_ts_arm = 1'b0;
      prev_ts    = 1'b0;
      prev_rdy   = 1'b0;
      prev_sb    = 1'b0;
      cur_grant  = 1'b0;
      req_valid  = '0;
      req_data   = '0;
      req_len    = '0;
      rstn       = 1'b1;
      #2 rstn    = 1'b0;
      repeat (3) tick();
      check_reset_outputs();
      rstn = 1'b1;
      repeat (2) tick();

      // 1: single byte from requester 0, with latency check
      ts_cnt  = 0;
      lat_arm = 1'b1;
      pend0_q.push_back({2'd0, 32'h0000_0041});
      expect_word(1'b0, 32'h0000_0041, 0);
      wait_done(300);
      check("t1_starts", 32'(ts_cnt), 32'd1);

      // 2: full word from requester 1
      ts_cnt = 0;
      pend1_q.push_back({2'd3, 32'hDEAD_BEEF});
      expect_word(1'b1, 32'hDEAD_BEEF, 3);
      wait_done(600);
      check("t2_starts", 32'(ts_cnt), 32'd4);

      // 3: contention, three single-byte words each -> 0,1,0,1,0,1
      ts_cnt = 0;
      for (int k = 0; k < 3; k++) begin
         pend0_q.push_back({2'd0, 32'(8'hA0 + k)});
         pend1_q.push_back({2'd0, 32'(8'hB0 + k)});
      end
      for (int k = 0; k < 3; k++) begin
         expect_word(1'b0, 32'(8'hA0 + k), 0);
         expect_word(1'b1, 32'(8'hB0 + k), 0);
      end
      wait_done(1200);
      check("t3_starts", 32'(ts_cnt), 32'd6);

      // 5: reset during the second byte; only the first byte arrives
      ts_cnt = 0;
      pend0_q.push_back({2'd3, 32'h1122_3344});
      exp_grant_q.push_back(1'b0);
      exp_byte_q.push_back(8'h44);
      for (int k = 0; k < 400; k++) begin
         tick();
         if (ts_cnt == 2) break;
      end
      check("t5_second_start", 32'(ts_cnt), 32'd2);
      repeat (20) tick();
      rstn = 1'b0;
      tick();
      check_reset_outputs();
      repeat (2) tick();
      rstn = 1'b1;
      tick();
      check("t5_no_partial", 32'(exp_byte_q.size()), 32'd0);
      lat_arm = 1'b1;
      pend0_q.push_back({2'd0, 32'h0000_0055});
      expect_word(1'b0, 32'h0000_0055, 0);
      wait_done(300);

      // 6: requester 0 withdraws while busy and is never granted
      pend1_q.push_back({2'd0, 32'h0000_0077});
      expect_word(1'b1, 32'h0000_0077, 0);
      for (int k = 0; k < 20; k++) begin
         tick();
         if (sched_busy) break;
      end
      check("t6_busy", 32'(sched_busy), 32'd1);
      req_data[31:0] = 32'h0000_0099;
      req_valid[0]   = 1'b1;
      tick();
      req_valid[0]   = 1'b0;
      pend1_q.push_back({2'd0, 32'h0000_0078});
      expect_word(1'b1, 32'h0000_0078, 0);
      wait_done(600);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
